round_nearest: RTL and testbench
================================

ROUND_NEAREST -- requirements
Module: round_nearest

Interface
REQ-001 SHALL have parameter STEP, default 10, rounding granularity; legal range 2..100.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port x  input  8  unsigned value to round.
REQ-005 SHALL have port in_valid  input  1  x is sampled on a clk edge where in_valid=1.
REQ-006 SHALL have port out  output  8  x rounded to nearest multiple of STEP, registered.
REQ-007 SHALL have port out_valid  output  1  high for exactly one cycle when out holds a new result.
REQ-008 SHALL have port sat  output  1  high together with out_valid when the result was saturated.

Function
REQ-009 SHALL compute r = x mod STEP and base = x - r, unsigned 8-bit arithmetic.
REQ-010 SHALL round half-up: result = base + STEP when 2*r >= STEP, else base (STEP=10: 26->30, 53->50, 25->30, 24->20).
REQ-011 SHALL evaluate base + STEP at 9-bit width; if it exceeds 255, out SHALL be base (the largest multiple of STEP <= 255) and sat=1 (STEP=10: 255->250, sat=1).
REQ-012 SHALL give latency exactly one cycle: x sampled at edge N with in_valid=1 appears on out, with out_valid=1, after edge N.
REQ-013 SHALL accept a new input every cycle (no back-pressure); back-to-back in_valid yields back-to-back out_valid.
REQ-014 SHALL hold out and sat unchanged when in_valid=0; out_valid SHALL drop to 0.
REQ-015 SHALL output 0 for x=0, and x unchanged whenever x is already a multiple of STEP.
REQ-016 SHALL be purely synchronous apart from reset; no combinational path from x to out.

Reset
REQ-017 SHALL, while rst_n=0, force out=0, out_valid=0, sat=0 immediately, independent of clk.
REQ-018 SHALL discard any input sampled in the cycle reset asserts; first valid result follows the first in_valid after rst_n deasserts.

Configuration
REQ-019 SHALL support macro ROUND_BCD_OUT_EN; when defined, add outputs bcd_hundreds[3:0], bcd_tens[3:0], bcd_ones[3:0], registered alongside out with the same latency and reset value 0.
REQ-020 SHALL, without ROUND_BCD_OUT_EN, have no BCD ports and no BCD logic; all other behaviour identical.

Structure
REQ-021 SHALL place STEP default, data width (8) and result-width constant (9) in shared package round_pkg.
REQ-022 SHALL implement the BCD conversion (when enabled) as sub-module bin2bcd8 (8-bit binary to three BCD digits, combinational).
REQ-023 SHALL implement mod/divide by constant STEP combinationally; no multi-cycle divider.

Verification
REQ-024 SHALL test STEP=10: x=26, in_valid=1 -> next cycle out=30, out_valid=1, sat=0.
REQ-025 SHALL test STEP=10: x=53 -> out=50; x=25 -> out=30; x=24 -> out=20.
REQ-026 SHALL test STEP=10: x=255 -> out=250, sat=1; x=250 -> out=250, sat=0.
REQ-027 SHALL test in_valid pulsed once then held 0 for 5 cycles -> out held, out_valid high exactly one cycle.
REQ-028 SHALL test rst_n low mid-stream (between clk edges) -> out=0, out_valid=0 immediately; resumes correctly after release.
REQ-029 SHALL test with ROUND_BCD_OUT_EN: x=26 -> out=30, bcd_hundreds=0, bcd_tens=3, bcd_ones=0.

Source files
------------

// File: rtl/round_pkg.sv
// round_pkg: shared constants for the round_nearest slice
package round_pkg;
    localparam int STEP_DEF = 10;
    localparam int DW       = 8;
    localparam int RW       = 9;
endpackage

// File: rtl/bin2bcd8.sv
// bin2bcd8: combinational 8-bit binary to three BCD digits
// Ports: bin_i (0..255) in; hundreds_o, tens_o, ones_o digits out.
// Only built with ROUND_BCD_OUT_EN, the sole configuration that uses it.
`ifdef ROUND_BCD_OUT_EN
module bin2bcd8
    import round_pkg::*;
(
    input  logic [DW-1:0] bin_i,
    output logic [3:0]    hundreds_o,
    output logic [3:0]    tens_o,
    output logic [3:0]    ones_o
);
    always_comb begin
        hundreds_o = 4'(bin_i / DW'(100));
        tens_o     = 4'((bin_i / DW'(10)) % DW'(10));
        ones_o     = 4'(bin_i % DW'(10));
    end
endmodule
`endif

// File: rtl/round_nearest.sv
// round_nearest: registered round-half-up of x to the nearest multiple of STEP
// Ports: clk, rst_n (async active-low), x/in_valid in; out/out_valid/sat out.
// Macro ROUND_BCD_OUT_EN adds registered bcd_hundreds/bcd_tens/bcd_ones of out.
module round_nearest
    import round_pkg::*;
#(
    parameter int STEP = STEP_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] x,
    input  logic          in_valid,
    output logic [DW-1:0] out,
    output logic          out_valid,
    output logic          sat
`ifdef ROUND_BCD_OUT_EN
    ,
    output logic [3:0]    bcd_hundreds,
    output logic [3:0]    bcd_tens,
    output logic [3:0]    bcd_ones
`endif
);
    logic [DW-1:0] r, base, out_d, out_q;
    logic [RW-1:0] up_sum;
    logic          up, ovf, sat_d, sat_q, valid_q;
    // Rounding up past 255 falls back to base, the largest multiple that fits.
    always_comb begin
        r      = x % DW'(STEP);
        base   = x - r;
        up     = {r, 1'b0} >= RW'(STEP);
        up_sum = {1'b0, base} + RW'(STEP);
        ovf    = up & up_sum[DW];
        out_d  = !in_valid ? out_q : (up & !ovf) ? up_sum[DW-1:0] : base;
        sat_d  = in_valid ? ovf : sat_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            sat_q   <= sat_d;
            valid_q <= in_valid;
        end
    end
    assign out       = out_q;
    assign sat       = sat_q;
    assign out_valid = valid_q;
`ifdef ROUND_BCD_OUT_EN
    logic [11:0] bcd_d, bcd_q;
    // Digits come from out_d so they stay aligned with out on every cycle.
    bin2bcd8 u_bcd (
        .bin_i      (out_d),
        .hundreds_o (bcd_d[11:8]),
        .tens_o     (bcd_d[7:4]),
        .ones_o     (bcd_d[3:0])
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bcd_q <= '0;
        else        bcd_q <= bcd_d;
    end
    assign bcd_hundreds = bcd_q[11:8];
    assign bcd_tens     = bcd_q[7:4];
    assign bcd_ones     = bcd_q[3:0];
`endif
endmodule

// File: tb/tb_round_nearest.sv
// tb_round_nearest: scoreboard bench for round_nearest with STEP=10
module tb_round_nearest;
    localparam int STEP = 10;
    typedef struct {
        logic [7:0] o;
        logic       s;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] x = '0;
    logic       in_valid = 1'b0;
    logic [7:0] out;
    logic       out_valid;
    logic       sat;
`ifdef ROUND_BCD_OUT_EN
    logic [3:0] bcd_hundreds, bcd_tens, bcd_ones;
`endif
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    round_nearest #(.STEP(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid),
        .sat       (sat)
`ifdef ROUND_BCD_OUT_EN
        ,
        .bcd_hundreds (bcd_hundreds),
        .bcd_tens     (bcd_tens),
        .bcd_ones     (bcd_ones)
`endif
    );
    always #5 clk = ~clk;
    // Half-up via integer arithmetic; overflow steps back one multiple.
    function automatic exp_t model(input int v);
        exp_t e;
        int   n;
        n = ((2 * v + STEP) / (2 * STEP)) * STEP;
        e.s = n > 255;
        e.o = 8'(e.s ? n - STEP : n);
        return e;
    endfunction
    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        x = 8'd99;
        @(negedge clk);
        total++; if (out !== 8'd0) begin bad++; $display("FAIL reset_out got=%0d exp=0", out); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b exp=0", sat); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || out !== 8'd0) begin bad++; $display("FAIL post_reset got=%b/%0d exp=0/0", out_valid, out); end
    endtask
    task automatic test_rounding(input int vals[$]);
        exp_t e;
        foreach (vals[i]) begin
            x = 8'(vals[i]);
            in_valid = 1'b1;
            sb.push_back(model(vals[i]));
            @(negedge clk);
            in_valid = 1'b0;
            e = sb.pop_front();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL round_valid x=%0d got=%b exp=1", vals[i], out_valid); end
            total++; if (out !== e.o) begin bad++; $display("FAIL round_out x=%0d got=%0d exp=%0d", vals[i], out, e.o); end
            total++; if (sat !== e.s) begin bad++; $display("FAIL round_sat x=%0d got=%b exp=%b", vals[i], sat, e.s); end
`ifdef ROUND_BCD_OUT_EN
            total++;
            if ({bcd_hundreds, bcd_tens, bcd_ones} !== {4'(e.o / 100), 4'((e.o / 10) % 10), 4'(e.o % 10)}) begin
                bad++; $display("FAIL round_bcd x=%0d got=%0d%0d%0d exp=%0d", vals[i], bcd_hundreds, bcd_tens, bcd_ones, e.o);
            end
`endif
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL round_idle x=%0d got=%b exp=0", vals[i], out_valid); end
        end
    endtask
    task automatic test_back_to_back(input int n);
        exp_t e;
        int   v;
        for (int i = 0; i <= n; i++) begin
            if (sb.size() != 0) begin
                e = sb.pop_front();
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid i=%0d got=%b exp=1", i, out_valid); end
                total++; if (out !== e.o || sat !== e.s) begin bad++; $display("FAIL b2b_out i=%0d got=%0d/%b exp=%0d/%b", i, out, sat, e.o, e.s); end
            end
            if (i < n) begin
                v = (i % 4 == 0) ? 255 - i : int'($urandom_range(0, 255));
                x = 8'(v);
                in_valid = 1'b1;
                sb.push_back(model(v));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", out_valid); end
    endtask
    task automatic test_hold();
        exp_t e;
        x = 8'd77;
        in_valid = 1'b1;
        sb.push_back(model(77));
        @(negedge clk);
        in_valid = 1'b0;
        e = sb.pop_front();
        total++; if (out_valid !== 1'b1 || out !== e.o) begin bad++; $display("FAIL hold_first got=%b/%0d exp=1/%0d", out_valid, out, e.o); end
        for (int i = 0; i < 5; i++) begin
            x = 8'($urandom_range(0, 255));
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_valid c=%0d got=%b exp=0", i, out_valid); end
            total++; if (out !== e.o || sat !== e.s) begin bad++; $display("FAIL hold_out c=%0d got=%0d/%b exp=%0d/%b", i, out, sat, e.o, e.s); end
        end
    endtask
    task automatic test_reset_mid();
        x = 8'd26;
        in_valid = 1'b1;
        @(posedge clk);
        x = 8'd53;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out !== 8'd0 || out_valid !== 1'b0 || sat !== 1'b0) begin bad++; $display("FAIL midreset got=%0d/%b/%b exp=0/0/0", out, out_valid, sat); end
        @(negedge clk);
        sb.delete();
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || out !== 8'd0) begin bad++; $display("FAIL midreset_discard got=%b/%0d exp=0/0", out_valid, out); end
        test_rounding('{24, 26});
    endtask
    initial begin
        test_reset();
        test_rounding('{26, 53, 25, 24, 0, 250, 255, 100, 5, 4, 245, 244, 249});
        test_hold();
        test_back_to_back(12);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
